// File: rtl/uart_word_assembler_if.sv
// Word-side valid/ready handshake between the UART word assembler and the RSA operand loader.
interface uart_word_assembler_if #(
    parameter int unsigned WORD_BITS = 32
);
    logic [WORD_BITS-1:0] word_out;
    logic                 word_valid;
    logic                 word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/uart_word_assembler.sv
// Packs consecutive UART bytes (first byte = MSB) into one operand word; discards partial
// words on BREAK or inter-byte timeout and flags bytes dropped while a word is still held.
module uart_word_assembler #(
    parameter int unsigned PAYLOAD_BITS   = 8,
    parameter int unsigned NUM_BYTES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned WORD_BITS     = PAYLOAD_BITS * NUM_BYTES,
    localparam int unsigned BC_W          = $clog2(NUM_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_break,
    uart_word_assembler_if.master   wif,
    output logic [BC_W-1:0]         byte_count,
    output logic                    timeout_pulse,
    output logic                    overrun_err
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t                 state_q,         state_d;
    logic [WORD_BITS-1:0]   shift_q,         shift_d;
    logic [WORD_BITS-1:0]   word_out_q,      word_out_d;
    logic                   word_valid_q,    word_valid_d;
    logic [BC_W-1:0]        byte_count_q,    byte_count_d;
    logic [TMO_W-1:0]       tmo_q,           tmo_d;
    logic                   timeout_pulse_q, timeout_pulse_d;
    logic                   overrun_err_q,   overrun_err_d;

    logic [WORD_BITS-1:0]   shift_next;
    logic                   handshake;

    assign shift_next = {shift_q[WORD_BITS-PAYLOAD_BITS-1:0], rx_data};
    assign handshake  = word_valid_q && wif.word_ready;

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        word_out_d      = word_out_q;
        word_valid_d    = word_valid_q;
        byte_count_d    = byte_count_q;
        tmo_d           = tmo_q;
        timeout_pulse_d = 1'b0;
        overrun_err_d   = overrun_err_q;

        unique case (state_q)
            COLLECT: begin
                if (rx_break) begin
                    shift_d      = '0;
                    byte_count_d = '0;
                    tmo_d        = '0;
                end else if (rx_valid) begin
                    shift_d = shift_next;
                    tmo_d   = '0;
                    if (byte_count_q == BC_W'(NUM_BYTES - 1)) begin
                        word_out_d   = shift_next;
                        word_valid_d = 1'b1;
                        byte_count_d = BC_W'(NUM_BYTES);
                        state_d      = FULL;
                    end else begin
                        byte_count_d = byte_count_q + 1'b1;
                    end
                end else if (byte_count_q != '0) begin
                    if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        shift_d         = '0;
                        byte_count_d    = '0;
                        tmo_d           = '0;
                        timeout_pulse_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            FULL: begin
                if (handshake) begin
                    word_valid_d = 1'b0;
                    byte_count_d = '0;
                    shift_d      = '0;
                    tmo_d        = '0;
                    state_d      = COLLECT;
                    // A byte landing on the handshake cycle opens the next word (zero-bubble path).
                    if (rx_valid && !rx_break) begin
                        shift_d      = WORD_BITS'(rx_data);
                        byte_count_d = BC_W'(1);
                    end
                end else if (rx_valid && !rx_break) begin
                    overrun_err_d = 1'b1;
                end
            end

            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= COLLECT;
            shift_q         <= '0;
            word_out_q      <= '0;
            word_valid_q    <= 1'b0;
            byte_count_q    <= '0;
            tmo_q           <= '0;
            timeout_pulse_q <= 1'b0;
            overrun_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            word_out_q      <= word_out_d;
            word_valid_q    <= word_valid_d;
            byte_count_q    <= byte_count_d;
            tmo_q           <= tmo_d;
            timeout_pulse_q <= timeout_pulse_d;
            overrun_err_q   <= overrun_err_d;
        end
    end

    assign wif.word_out   = word_out_q;
    assign wif.word_valid = word_valid_q;
    assign byte_count     = byte_count_q;
    assign timeout_pulse  = timeout_pulse_q;
    assign overrun_err    = overrun_err_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: directed scenarios plus randomized traffic against a byte-queue model.
module tb_uart_word_assembler;

    localparam int unsigned P = 8;
    localparam int unsigned N = 4;
    localparam int unsigned T = 16;
    localparam int unsigned W = P * N;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [P-1:0]             rx_data;
    logic                     rx_valid;
    logic                     rx_break;
    logic [$clog2(N+1)-1:0]   byte_count;
    logic                     timeout_pulse;
    logic                     overrun_err;

    uart_word_assembler_if #(.WORD_BITS(W)) wif ();

    uart_word_assembler #(
        .PAYLOAD_BITS  (P),
        .NUM_BYTES     (N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_break     (rx_break),
        .wif          (wif),
        .byte_count   (byte_count),
        .timeout_pulse(timeout_pulse),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    // Reference model: bytes gathered so far, held word, cycles idle since the last byte.
    logic [P-1:0] m_bytes[$];
    bit           m_full;
    logic [W-1:0] m_word;
    int unsigned  m_idle;
    bit           m_pulse;
    bit           m_ovr;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [P-1:0] d,
                              input bit b, input bit rdy);
        logic [W-1:0] acc;
        m_pulse = 1'b0;
        if (r) begin
            m_bytes.delete();
            m_full = 1'b0;
            m_word = '0;
            m_idle = 0;
            m_ovr  = 1'b0;
        end else if (m_full) begin
            if (rdy) begin
                m_full = 1'b0;
                m_bytes.delete();
                m_idle = 0;
                if (v && !b) m_bytes.push_back(d);
            end else if (v && !b) begin
                m_ovr = 1'b1;
            end
        end else if (b) begin
            m_bytes.delete();
            m_idle = 0;
        end else if (v) begin
            m_bytes.push_back(d);
            m_idle = 0;
            if (m_bytes.size() == N) begin
                acc = '0;
                foreach (m_bytes[i]) acc = (acc << P) | W'(m_bytes[i]);
                m_word = acc;
                m_full = 1'b1;
                m_bytes.delete();
            end
        end else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_bytes.delete();
                m_idle  = 0;
                m_pulse = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int unsigned exp_bc;
        exp_bc = m_full ? N : m_bytes.size();
        check_eq("word_valid",    64'(wif.word_valid), 64'(m_full));
        check_eq("word_out",      64'(wif.word_out),   64'(m_word));
        check_eq("byte_count",    64'(byte_count),     64'(exp_bc));
        check_eq("timeout_pulse", 64'(timeout_pulse),  64'(m_pulse));
        check_eq("overrun_err",   64'(overrun_err),    64'(m_ovr));
    endtask

    task automatic cycle(input bit r, input bit v, input logic [P-1:0] d,
                         input bit b, input bit rdy);
        rst            = r;
        rx_valid       = v;
        rx_data        = d;
        rx_break       = b;
        wif.word_ready = rdy;
        @(posedge clk);
        model_step(r, v, d, b, rdy);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [P-1:0] d, input bit rdy);
        cycle(1'b0, 1'b1, d, 1'b0, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, '0, 1'b0, rdy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rate;
        int unsigned rdy_rate;
        logic [P-1:0] seq[4];

        m_full = 1'b0; m_word = '0; m_idle = 0; m_pulse = 1'b0; m_ovr = 1'b0;

        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_eq("reset_word_out", 64'(wif.word_out), 64'h0);
        check_eq("reset_bc",       64'(byte_count),   64'h0);

        // DEADBEEF with word_ready held high.
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (seq[i]) send(seq[i], 1'b1);
        check_eq("deadbeef_valid", 64'(wif.word_valid), 64'h1);
        check_eq("deadbeef_word",  64'(wif.word_out),   64'hDEADBEEF);
        idle(1'b1);
        check_eq("deadbeef_drain_bc", 64'(byte_count), 64'h0);

        // Handshake and new byte in the same cycle.
        seq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        foreach (seq[i]) send(seq[i], 1'b0);
        send(8'hAA, 1'b1);
        check_eq("hs_byte_bc",  64'(byte_count),  64'h1);
        check_eq("hs_byte_ovr", 64'(overrun_err), 64'h0);
        send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
        check_eq("hs_next_word", 64'(wif.word_out), 64'hAABBCCDD);
        idle(1'b1);

        // Overrun while a word is held.
        seq = '{8'h01, 8'h02, 8'h03, 8'h04};
        foreach (seq[i]) send(seq[i], 1'b0);
        send(8'h55, 1'b0);
        check_eq("ovr_word", 64'(wif.word_out), 64'h01020304);
        check_eq("ovr_flag", 64'(overrun_err),  64'h1);
        idle(1'b1);
        check_eq("ovr_drain_valid", 64'(wif.word_valid), 64'h0);
        check_eq("ovr_drain_bc",    64'(byte_count),     64'h0);

        // Reset while FULL with overrun set.
        seq = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        foreach (seq[i]) send(seq[i], 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_eq("rst_full_valid", 64'(wif.word_valid), 64'h0);
        check_eq("rst_full_word",  64'(wif.word_out),   64'h0);
        check_eq("rst_full_ovr",   64'(overrun_err),    64'h0);

        // Timeout after two bytes.
        send(8'h77, 1'b0); send(8'h88, 1'b0);
        for (int i = 1; i <= 16; i++) idle(1'b0);
        check_eq("tmo_pulse16", 64'(timeout_pulse), 64'h1);
        check_eq("tmo_bc",      64'(byte_count),    64'h0);
        idle(1'b0);
        check_eq("tmo_pulse_off", 64'(timeout_pulse), 64'h0);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seq[i]) send(seq[i], 1'b0);
        check_eq("tmo_next_word", 64'(wif.word_out), 64'h11223344);

        // BREAK in FULL keeps the held word.
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_eq("brk_full_word",  64'(wif.word_out),   64'h11223344);
        check_eq("brk_full_valid", 64'(wif.word_valid), 64'h1);
        idle(1'b1);

        // BREAK mid-word discards it without a timeout pulse.
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_eq("brk_bc", 64'(byte_count), 64'h0);
        for (int i = 0; i < 20; i++) idle(1'b0);

        // Randomized traffic in segments of differing byte density and consumer readiness.
        for (int s = 0; s < 50; s++) begin
            case ($urandom_range(0, 3))
                0:       rate = 0;
                1:       rate = 8;
                2:       rate = 50;
                default: rate = 100;
            endcase
            rdy_rate = $urandom_range(0, 100);
            for (int c = 0; c < 60; c++) begin
                cycle($urandom_range(0, 499) == 0,
                      $urandom_range(0, 99) < rate,
                      P'($urandom),
                      $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < rdy_rate);
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
